// File: rtl/piezo_tone_seq.sv
// piezo_tone_seq
//   Note-table square-wave generator for a piezo buzzer, with octave shift
//   and a tick prescaler. Two play modes:
//     hold     - the tone follows a held key until key_valid drops or a
//                rest key is presented.
//     one-shot - the tone lasts `duration` ticks, then finishes its current
//                high half period and pulses note_done.
//   Note changes and note stops only take effect at half-period boundaries,
//   so the output never produces a runt pulse.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset (0 = reset)
//   key        in   note index 0..13, 14/15 = rest
//   key_valid  in   key/octave/duration/mode are valid
//   mode       in   0 = hold, 1 = one-shot (sampled in IDLE)
//   octave     in   right shift on the table limit, 3 behaves as 2
//   duration   in   one-shot length in ticks
//   piezo      out  square-wave output
//   busy       out  high whenever the sequencer is not IDLE
//   note_done  out  one-cycle pulse when a one-shot note or rest completes
//
// Handshake: the upstream sequencer presents key/octave/duration/mode with
// key_valid while busy is low; the block accepts on that rising edge and
// raises busy. For one-shot notes note_done pulses on the edge that returns
// the block to IDLE, and a key_valid seen on the following edge is accepted
// immediately, so consecutive notes run with no dead tick.
module piezo_tone_seq #(
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 1,
  parameter int DUR_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       key,
  input  logic             key_valid,
  input  logic             mode,
  input  logic [1:0]       octave,
  input  logic [DUR_W-1:0] duration,
  output logic             piezo,
  output logic             busy,
  output logic             note_done
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD    = 2'd1,
    S_ONESHOT = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t           state;
  logic [PRE_W-1:0] pre;
  logic             tick;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] lim;
  logic [1:0]       shift;
  logic [3:0]       key_l;
  logic [1:0]       oct_l;
  logic [DUR_W-1:0] dcnt;
  logic             from_os;
  logic             is_rest;
  logic             toggle;
  logic             piezo_nx;

  // Free-running prescaler; tick marks the last cycle of each tick period.
  assign tick = (pre == PRE_W'(PRESCALE - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // Half-period limits from the latched key. Rests reuse key 0's limit so
  // that rest timing stays on the same grid as a real note.
  always_comb begin
    base = CNT_W'(1911);
    case (key_l)
      4'd0:    base = CNT_W'(1911);
      4'd1:    base = CNT_W'(1702);
      4'd2:    base = CNT_W'(1516);
      4'd3:    base = CNT_W'(1431);
      4'd4:    base = CNT_W'(1275);
      4'd5:    base = CNT_W'(1136);
      4'd6:    base = CNT_W'(1012);
      4'd7:    base = CNT_W'(955);
      4'd8:    base = CNT_W'(851);
      4'd9:    base = CNT_W'(758);
      4'd10:   base = CNT_W'(715);
      4'd11:   base = CNT_W'(637);
      4'd12:   base = CNT_W'(568);
      4'd13:   base = CNT_W'(506);
      default: base = CNT_W'(1911);
    endcase
    shift = (oct_l == 2'd3) ? 2'd2 : oct_l;
    lim   = base >> shift;
  end

  assign is_rest  = (key_l >= 4'd14);
  assign toggle   = tick && (cnt >= lim);
  assign piezo_nx = is_rest ? 1'b0 : ~piezo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      dcnt      <= '0;
      piezo     <= 1'b0;
      busy      <= 1'b0;
      note_done <= 1'b0;
      key_l     <= '0;
      oct_l     <= '0;
      from_os   <= 1'b0;
    end else begin
      note_done <= 1'b0;

      // Tone counter runs in every active state; state branches below may
      // override cnt/piezo when returning to IDLE.
      if (state != S_IDLE && tick) begin
        if (cnt >= lim) begin
          cnt   <= '0;
          piezo <= piezo_nx;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      case (state)
        S_IDLE: begin
          cnt   <= '0;
          piezo <= 1'b0;
          if (key_valid) begin
            if (mode) begin
              key_l   <= key;
              oct_l   <= octave;
              dcnt    <= duration;
              from_os <= 1'b1;
              busy    <= 1'b1;
              state   <= S_ONESHOT;
            end else if (key < 4'd14) begin
              key_l   <= key;
              oct_l   <= octave;
              from_os <= 1'b0;
              busy    <= 1'b1;
              state   <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (!key_valid) begin
            state <= S_RELEASE;
          end else if (toggle) begin
            // New key takes effect for the next half period only.
            if (key >= 4'd14) begin
              state <= S_RELEASE;
            end else begin
              key_l <= key;
              oct_l <= octave;
            end
          end
        end

        S_ONESHOT: begin
          if (dcnt == '0) begin
            // Zero-length note: finish straight away.
            state     <= S_IDLE;
            busy      <= 1'b0;
            note_done <= 1'b1;
            cnt       <= '0;
            piezo     <= 1'b0;
          end else if (tick) begin
            dcnt <= dcnt - DUR_W'(1);
            if (dcnt == DUR_W'(1)) begin
              state <= S_RELEASE;
            end
          end
        end

        S_RELEASE: begin
          // With piezo high, the toggle point is the 1->0 transition.
          if (!piezo || toggle) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            note_done <= from_os;
            cnt       <= '0;
            piezo     <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
